fetch_queue_unit: RTL
=====================

Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch stage for the 32-bit MIPS pipeline; successor to the single-register fetch.
- Generates PCs, issues requests to the instruction cache and buffers returned instructions with their PCs in a DEPTH-entry FIFO.
- Presents instructions to decode with a valid/ready handshake.
- Accepts jump redirects from decode and branch redirects from execute; a redirect flushes the buffer and squashes any in-flight fetch.

Parameters:
ADDR_W, 32, PC and cache address width
DATA_W, 32, instruction width
DEPTH, 4, instruction FIFO entries; power of 2, >=2
RESET_PC, 32'h0000_0000, PC loaded on reset
PC_INC, 4, sequential PC increment in bytes

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
icache_req  out  1  fetch request valid
icache_addr  out  ADDR_W  fetch address, word aligned
icache_ready  in  1  cache accepts request this cycle
icache_rdata  in  DATA_W  instruction; valid exactly 1 cycle after acceptance
instr_valid  out  1  FIFO head valid
instr  out  DATA_W  FIFO head instruction
instr_pc  out  ADDR_W  PC of FIFO head
instr_ready  in  1  decode consumes head
jump_valid  in  1  decode-stage jump redirect
jump_target  in  ADDR_W  jump target
branch_valid  in  1  execute-stage taken-branch redirect
branch_target  in  ADDR_W  branch target
misalign_err  out  1  one-cycle pulse: redirect target low 2 bits nonzero
occupancy  out  $clog2(DEPTH)+1  valid FIFO entries

Behaviour:
- Reset (rst low, asynchronous): pc=RESET_PC, FIFO empty, inflight=0. All outputs 0, except icache_addr, which shows RESET_PC. Reset mid-operation discards everything, including an in-flight response.
- Issue rule: icache_req = (occupancy + inflight < DEPTH) && !redirect, where redirect = branch_valid || jump_valid.
- icache_addr = pc.
- Acceptance: icache_req && icache_ready. On acceptance: pc <= pc + PC_INC, inflight <= 1, inflight_pc <= pc. Otherwise inflight <= 0.
- At most one request is outstanding per cycle; back-to-back acceptance is allowed, since each response arrives the next cycle.
- Response: in the cycle after acceptance, if not squashed, {icache_rdata, inflight_pc} is written at the FIFO tail. icache_ready low: pc holds, request re-presented.
- Latency: request accepted in cycle N gives instr_valid in cycle N+2 (registered FIFO output; no bypass). Sustained throughput is 1 instr/cycle when DEPTH>=2 and decode is always ready.
- Pop: instr_valid && instr_ready advances the head. Simultaneous push and pop: occupancy unchanged.
- Overflow is impossible by construction, because the issue rule counts the in-flight slot. A push when full is an assertion failure.
- Pointers wrap modulo DEPTH.
- Redirect priority: branch_valid over jump_valid; branch is the older instruction.
- Redirect cycle:
  - icache_req forced 0.
  - FIFO cleared next edge; occupancy 0, instr_valid 0 next cycle.
  - Any response arriving next cycle is squashed (inflight cleared).
  - pc <= {target[ADDR_W-1:2], 2'b00}.
  - A pop in the redirect cycle still completes; the handshake holds at that edge.
- Fetch from the new pc begins the cycle after the redirect; its instruction is at the head 2 cycles later if icache_ready.
- misalign_err pulses 1 cycle after a selected redirect whose target[1:0] != 0. It reflects only the selected target.
- instr/instr_pc hold their value while instr_valid && !instr_ready; they are stable until the pop.
- Counters: occupancy saturates neither way; it is exact 0..DEPTH.

Test Plan:
- Stream: DEPTH=4, ready always 1, rdata=pc-derived tag → instr_pc sequence 0,4,8,12… from cycle 2 after reset; one instr per cycle; occupancy stays ≤2.
- Backpressure: instr_ready=0 for 10 cycles → occupancy reaches 4, icache_req drops after 4th acceptance, no data lost. Release → PCs 0,4,8,12 then 16 continue in order.
- Branch squash: branch_valid with target 0x100 the cycle after a fetch of 0x20 is accepted → 0x20 never appears at instr_pc, FIFO empties, next instr_pc = 0x100.
- Simultaneous: branch_valid (0x200) and jump_valid (0x300) same cycle → next instr_pc = 0x200; 0x300 never fetched.
- Misalign and stall: jump_target 0x1_0006 → icache_addr 0x1_0004, misalign_err one pulse. icache_ready low 3 cycles → pc held at 0x1_0004, no duplicate FIFO entries.
- Async reset: drop rst mid-stream between clock edges → outputs 0 immediately, icache_addr=RESET_PC. After release, stream restarts at RESET_PC with no stale instruction.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: issues PCs to the instruction cache and buffers the returned
// instructions with their PCs in a small FIFO. Jump and branch redirects flush the FIFO.
module fetch_queue_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_INC   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       icache_req,
    output logic [ADDR_W-1:0]          icache_addr,
    input  logic                       icache_ready,
    input  logic [DATA_W-1:0]          icache_rdata,
    output logic                       instr_valid,
    output logic [DATA_W-1:0]          instr,
    output logic [ADDR_W-1:0]          instr_pc,
    input  logic                       instr_ready,
    input  logic                       jump_valid,
    input  logic [ADDR_W-1:0]          jump_target,
    input  logic                       branch_valid,
    input  logic [ADDR_W-1:0]          branch_target,
    output logic                       misalign_err,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic              inflight_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              misalign_q;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  pending;
    logic              accept;
    logic              push;
    logic              pop;

    // Branch is the older instruction, so it wins over a same-cycle jump.
    assign redirect = branch_valid || jump_valid;
    assign target   = branch_valid ? branch_target : jump_target;

    // The in-flight slot is counted so a returning response always has room.
    assign pending    = count_q + CNT_W'(inflight_q);
    assign icache_req = rst && (pending < CNT_W'(DEPTH)) && !redirect;
    assign accept     = icache_req && icache_ready;
    assign push       = inflight_q && !redirect;
    assign pop        = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            misalign_q    <= 1'b0;
        end else begin
            misalign_q <= redirect && (target[1:0] != 2'b00);
            if (redirect) begin
                pc_q       <= {target[ADDR_W-1:2], 2'b00};
                inflight_q <= 1'b0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
            end else begin
                inflight_q <= accept;
                if (accept) begin
                    pc_q          <= pc_q + ADDR_W'(PC_INC);
                    inflight_pc_q <= pc_q;
                end
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= icache_rdata;
            pc_mem[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    // Entry storage has no reset; outputs are masked so an empty queue reads as zero.
    assign instr_valid  = (count_q != '0);
    assign instr        = instr_valid ? data_mem[rd_ptr_q] : '0;
    assign instr_pc     = instr_valid ? pc_mem[rd_ptr_q] : '0;
    assign icache_addr  = pc_q;
    assign misalign_err = misalign_q;
    assign occupancy    = count_q;

    assert property (@(posedge clk) disable iff (!rst) push |-> (count_q != CNT_W'(DEPTH)))
        else $error("fetch_queue_unit: push into full FIFO");

endmodule
